// File: rtl/dclk_rx_fifo.sv
// -----------------------------------------------------------------------------
// dclk_rx_fifo
//   Router-input serial flit receiver. Deserialises start-bit-framed flits
//   arriving on LANES serial wires and queues them in a DEPTH-entry FIFO.
//   Frame: one start beat (lane 0 = 1, other lanes ignored), then
//   NB = FLIT_W/LANES data beats. Beat k carries flit[k*LANES +: LANES].
//   Frames may follow each other with no idle beat in between.
//   FIFO space is reserved for a frame while it is being received, so the
//   sender sees channel_busy only when no free slot remains. A frame that
//   starts while busy is consumed and discarded, with a one-cycle dropped pulse.
//
// Ports
//   i_clk           single clock, all logic on posedge
//   i_reset         synchronous, active-high
//   i_serial_in     serial data lanes; lane 0 also carries the start bit
//   i_item_read     consumer pops the FIFO head this cycle (ignored when empty)
//   o_valid         FIFO not empty
//   o_parallel_out  head flit when o_valid, 0 otherwise
//   o_channel_busy  sender must not start a new frame
//   o_dropped       one-cycle pulse after a discarded frame's last beat
//
// FSM states
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   S_IDLE    | waiting for a start bit on lane 0
//   S_RECV    | receiving a frame into a reserved FIFO slot; commit on last beat
//   S_DISCARD | consuming a frame that arrived while busy; pulse dropped at end
// -----------------------------------------------------------------------------
module dclk_rx_fifo #(
  parameter int    FLIT_W = 16,
  parameter int    LANES  = 1,
  parameter int    DEPTH  = 4,
  parameter string PORT   = "unknown"
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [LANES-1:0]  i_serial_in,
  input  logic              i_item_read,
  output logic              o_valid,
  output logic [FLIT_W-1:0] o_parallel_out,
  output logic              o_channel_busy,
  output logic              o_dropped
);

  localparam int NB = FLIT_W / LANES;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam int PW = $clog2(DEPTH);

  localparam logic [CW-1:0] LAST_BEAT = CW'(NB - 1);
  localparam logic [CW-1:0] BEAT_ONE  = CW'(1);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [PW:0]   CNT_ONE   = (PW + 1)'(1);
  localparam logic [PW:0]   CNT_FULL  = (PW + 1)'(DEPTH);
  localparam logic [PW+1:0] OCC_FULL  = (PW + 2)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RECV    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [CW-1:0]     r_beat;
  logic [FLIT_W-1:0] w_flit;
  logic              w_last;
  logic              w_push;
  logic              w_drop;
  logic              w_pop;
  logic              w_res;
  logic [PW+1:0]     w_occ;

  logic [FLIT_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]     r_head;
  logic [PW-1:0]     r_tail;
  logic [PW:0]       r_count;
  logic [PW:0]       w_count_nxt;
  logic              r_dropped;

  // ---------------------------------------------------------------------------
  // Flow control: a frame in RECV already owns one slot.
  // ---------------------------------------------------------------------------
  assign w_res          = (r_state == S_RECV);
  assign w_occ          = {1'b0, r_count} + {{(PW + 1){1'b0}}, w_res};
  assign o_channel_busy = (w_occ >= OCC_FULL);

  assign w_last = (r_beat == LAST_BEAT);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_serial_in[0]) begin
          w_state_nxt = o_channel_busy ? S_DISCARD : S_RECV;
        end
      end
      S_RECV: begin
        if (w_last) begin
          w_state_nxt = S_IDLE;
          w_push      = 1'b1;
        end
      end
      S_DISCARD: begin
        if (w_last) begin
          w_state_nxt = S_IDLE;
          w_drop      = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Beat counter and deserialiser
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_beat <= '0;
    end else if (r_state != S_IDLE) begin
      r_beat <= w_last ? '0 : (r_beat + BEAT_ONE);
    end
  end

  // The shift register holds only the beats already received; the current
  // beat is taken straight from the line so the flit can commit on the last
  // beat without an extra cycle.
  if (NB > 1) begin : g_shift
    logic [FLIT_W-LANES-1:0] r_shift;

    always_ff @(posedge i_clk) begin
      if (i_reset) begin
        r_shift <= '0;
      end else if (r_state != S_IDLE) begin
        r_shift <= w_flit[FLIT_W-1:LANES];
      end
    end

    assign w_flit = {i_serial_in, r_shift};
  end else begin : g_no_shift
    assign w_flit = i_serial_in;
  end

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  assign o_valid = (r_count != '0);
  assign w_pop   = i_item_read && o_valid;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_ONE;
      2'b01:   w_count_nxt = r_count - CNT_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_dropped <= 1'b0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + PTR_ONE;
      end
      if (w_pop) begin
        r_head <= r_head + PTR_ONE;
      end
      r_count   <= w_count_nxt;
      r_dropped <= w_drop;
    end
  end

  // Storage is not cleared on reset; the pointers and count define contents.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_tail] <= w_flit;
    end
  end

  // The reservation scheme guarantees a commit never meets a full FIFO.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      assert (!(w_push && (r_count == CNT_FULL)))
        else $warning("dclk_rx_fifo %s: commit into full FIFO", PORT);
    end
  end

  assign o_parallel_out = o_valid ? r_mem[r_head] : '0;
  assign o_dropped      = r_dropped;

endmodule
